// File: rtl/useq_ctrl.sv
// useq_ctrl: microsequencer owning the instruction register and T-state counter,
// with memory wait states, halt and single-step at instruction boundaries.
module useq_ctrl #(
  parameter int II_BIT  = 6,
  parameter int RT_BIT  = 11,
  parameter int MEM_BIT = 15,
  parameter int MAX_T   = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bus_in,
  input  logic [15:0] uinstr,
  input  logic        mem_ready,
  input  logic        halt_req,
  input  logic        step,
  output logic [15:0] instr,
  output logic [2:0]  T,
  output logic        uinstr_en,
  output logic        halted,
  output logic        t_overrun
);
  typedef enum logic [1:0] {RUN, STALL, HALT, STEP} state_t;
  state_t      r_state, w_state_nxt;
  logic        r_from_step, w_from_step_nxt;
  logic [15:0] r_instr;
  logic [2:0]  r_t;
  logic        r_ovr;
  logic        w_mem, w_rt, w_ii, w_active, w_en, w_wrap, w_bound, w_in_step, w_stop, w_unused;
  assign w_mem     = uinstr[MEM_BIT];
  assign w_rt      = uinstr[RT_BIT];
  assign w_ii      = uinstr[II_BIT];
  assign w_unused  = ^uinstr;
  assign w_active  = (r_state == RUN) || (r_state == STEP);
  assign w_en      = w_active ? (!w_mem || mem_ready) : (r_state == STALL) && mem_ready;
  assign w_wrap    = r_t == 3'(MAX_T);
  assign w_bound   = w_en && (w_rt || w_wrap);
  // A stall remembers whether it interrupted a single-stepped instruction
  assign w_in_step = (r_state == STEP) || ((r_state == STALL) && r_from_step);
  assign w_stop    = w_bound && (w_in_step || halt_req);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_from_step <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_from_step <= w_from_step_nxt;
    end
  end
  always_comb begin
    w_state_nxt     = r_state;
    w_from_step_nxt = r_from_step;
    if (w_active && w_mem && !mem_ready) begin
      w_state_nxt     = STALL;
      w_from_step_nxt = r_state == STEP;
    end else if (r_state == HALT)
      w_state_nxt = !halt_req ? RUN : step ? STEP : HALT;
    else if (w_en)
      w_state_nxt = w_stop ? HALT : w_in_step ? STEP : RUN;
  end
  always_comb begin
    uinstr_en = w_en;
    halted    = r_state == HALT;
    instr     = r_instr;
    T         = r_t;
    t_overrun = r_ovr;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_instr <= '0;
      r_t     <= '0;
      r_ovr   <= 1'b0;
    end else if (w_en) begin
      if (w_ii) r_instr <= bus_in;
      r_t <= (w_rt || w_wrap) ? 3'd0 : r_t + 3'd1;
      if (!w_rt && w_wrap) r_ovr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_useq_ctrl.sv
// tb_useq_ctrl: directed cycle-by-cycle checks of the microsequencer.
module tb_useq_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bus_in = '0, uinstr = '0;
  logic        mem_ready = 1'b0, halt_req = 1'b0, step = 1'b0;
  logic [15:0] instr;
  logic [2:0]  T;
  logic        uinstr_en, halted, t_overrun;
  int          n_chk = 0, n_err = 0;
  localparam logic [15:0] II = 16'h0040, RT = 16'h0800, MEM = 16'h8000, Z = 16'h0000;
  useq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .bus_in(bus_in), .uinstr(uinstr),
    .mem_ready(mem_ready), .halt_req(halt_req), .step(step),
    .instr(instr), .T(T), .uinstr_en(uinstr_en), .halted(halted), .t_overrun(t_overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cy(input string tag, input logic [15:0] u, input logic [15:0] b,
                    input logic mr, input logic hr, input logic st,
                    input logic [2:0] e_t, input logic [15:0] e_i,
                    input logic e_en, input logic e_h, input logic e_o);
    uinstr = u; bus_in = b; mem_ready = mr; halt_req = hr; step = st;
    #1;
    chk({tag, ".T"}, 16'(T), 16'(e_t));
    chk({tag, ".instr"}, instr, e_i);
    chk({tag, ".en"}, 16'(uinstr_en), 16'(e_en));
    chk({tag, ".halted"}, 16'(halted), 16'(e_h));
    chk({tag, ".ovr"}, 16'(t_overrun), 16'(e_o));
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    cy("rst", Z, Z, 1, 0, 0, 0, 16'h0000, 1, 0, 0);
    reset_n = 1'b1;
    cy("run_t0", Z, Z, 1, 0, 0, 0, 16'h0000, 1, 0, 0);
    cy("run_t1", II, 16'h0300, 1, 0, 0, 1, 16'h0000, 1, 0, 0);
    cy("run_t2", RT, Z, 1, 0, 0, 2, 16'h0300, 1, 0, 0);
    cy("st_t0", Z, Z, 1, 0, 0, 0, 16'h0300, 1, 0, 0);
    cy("st_w1", II | MEM, 16'h1111, 0, 0, 0, 1, 16'h0300, 0, 0, 0);
    cy("st_w2", II | MEM, 16'h1111, 0, 0, 0, 1, 16'h0300, 0, 0, 0);
    cy("st_w3", II | MEM, 16'h1111, 0, 0, 0, 1, 16'h0300, 0, 0, 0);
    cy("st_go", II | MEM, 16'h1111, 1, 0, 0, 1, 16'h0300, 1, 0, 0);
    cy("st_t2", RT, Z, 0, 0, 0, 2, 16'h1111, 1, 0, 0);
    for (int i = 0; i < 8; i++)
      cy($sformatf("ov_t%0d", i), Z, Z, 0, 0, 0, 3'(i), 16'h1111, 1, 0, 0);
    cy("ov_wrap", RT, Z, 0, 0, 0, 0, 16'h1111, 1, 0, 1);
    cy("ov_rt0", RT, Z, 0, 0, 0, 0, 16'h1111, 1, 0, 1);
    cy("h_t0", Z, Z, 0, 0, 0, 0, 16'h1111, 1, 0, 1);
    cy("h_t1", Z, Z, 0, 1, 0, 1, 16'h1111, 1, 0, 1);
    cy("h_t2", RT, Z, 0, 1, 0, 2, 16'h1111, 1, 0, 1);
    cy("h_halt1", MEM, Z, 1, 1, 0, 0, 16'h1111, 0, 1, 1);
    cy("h_halt2", II, 16'hffff, 1, 1, 0, 0, 16'h1111, 0, 1, 1);
    cy("h_stp", Z, Z, 0, 1, 1, 0, 16'h1111, 0, 1, 1);
    cy("s_t0", Z, Z, 0, 1, 0, 0, 16'h1111, 1, 0, 1);
    cy("s_t1", Z, Z, 0, 1, 0, 1, 16'h1111, 1, 0, 1);
    cy("s_t2", RT, Z, 0, 1, 0, 2, 16'h1111, 1, 0, 1);
    cy("s_halt", Z, Z, 0, 1, 0, 0, 16'h1111, 0, 1, 1);
    cy("r_drop", Z, Z, 0, 0, 1, 0, 16'h1111, 0, 1, 1);
    cy("r_t0", Z, Z, 0, 0, 0, 0, 16'h1111, 1, 0, 1);
    cy("r_stpign", Z, Z, 0, 0, 1, 1, 16'h1111, 1, 0, 1);
    cy("r_t2", RT, Z, 0, 0, 0, 2, 16'h1111, 1, 0, 1);
    cy("x_t0", Z, Z, 0, 0, 0, 0, 16'h1111, 1, 0, 1);
    cy("x_t1", II, 16'h6400, 0, 0, 0, 1, 16'h1111, 1, 0, 1);
    cy("x_w1", MEM, Z, 0, 0, 0, 2, 16'h6400, 0, 0, 1);
    reset_n = 1'b0;
    cy("x_w2", MEM, Z, 0, 0, 0, 2, 16'h6400, 0, 0, 1);
    reset_n = 1'b1;
    cy("x_rst", Z, Z, 0, 0, 0, 0, 16'h0000, 1, 0, 0);
    cy("x_run", Z, Z, 0, 0, 0, 1, 16'h0000, 1, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
